// File: rtl/xnor_gate_pkg.sv
// Shared constants and helpers for the xnor_gate_unit block.
package xnor_gate_pkg;

   // Default operand width in bits.
   localparam int DEFAULT_WIDTH = 8;

   // Width needed to hold a count in the range 0..width.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : xnor_gate_pkg

// File: rtl/xnor_cell.sv
// One-bit XNOR cell built only from gate primitives:
// c = (a AND b) OR (NOT a AND NOT b).
module xnor_cell (
   input  logic a,
   input  logic b,
   output wire  c
);

   wire a_n;
   wire b_n;
   wire both_hi;
   wire both_lo;

   not u_not_a (a_n, a);
   not u_not_b (b_n, b);
   and u_and_hi (both_hi, a, b);
   and u_and_lo (both_lo, a_n, b_n);
   or  u_or_c   (c, both_hi, both_lo);

endmodule : xnor_cell

// File: rtl/xnor_gate_unit.sv
// Registered bitwise XNOR (bit-equality) unit. The same result is computed
// three ways (dataflow, behavioural, structural) so the copies can be
// cross-checked. It also reports how many bit positions of a and b are equal.
//
// Build option: define XNOR_CROSSCHECK_EN to build the comparator that drives
// the sticky mismatch flag. Without it, mismatch is tied to 0. The port list is
// identical in both builds.
module xnor_gate_unit
   import xnor_gate_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c_df,
   output logic [WIDTH-1:0] c_bh,
   output logic [WIDTH-1:0] c_st,
   output logic [CNT_W-1:0] match_cnt,
   output logic             all_eq,
   output logic             out_valid,
   output logic             mismatch
);

   logic [WIDTH-1:0] c_df_comb;
   logic [WIDTH-1:0] c_bh_comb;
   wire  [WIDTH-1:0] c_st_comb;
   logic [CNT_W-1:0] cnt_comb;

   // Dataflow copy: a single continuous assignment.
   assign c_df_comb = ~(a ^ b);

   // Behavioural copy: per-bit truth table lookup.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      c_bh_comb = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case ({a[i], b[i]})
            2'b00:   c_bh_comb[i] = 1'b1;
            2'b11:   c_bh_comb[i] = 1'b1;
            default: c_bh_comb[i] = 1'b0;
         endcase
      end
   end

   // Structural copy: one gate-level cell per bit.
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      xnor_cell u_cell (
         .a (a[g]),
         .b (b[g]),
         .c (c_st_comb[g])
      );
   end

   // Popcount of the dataflow result: number of equal bit positions.
   always_comb begin
      cnt_comb = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_comb = cnt_comb + CNT_W'(c_df_comb[i]);
      end
   end

`ifdef XNOR_CROSSCHECK_EN
   logic copies_differ;

   // Comparator: any disagreement between the three combinational copies.
   assign copies_differ = (c_df_comb != c_bh_comb) || (c_df_comb != c_st_comb);
`else
   assign mismatch = 1'b0;
`endif

   // Result registers: capture on in_valid, hold otherwise; reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
         c_df      <= '0;
         c_bh      <= '0;
         c_st      <= '0;
         match_cnt <= '0;
         all_eq    <= 1'b0;
         out_valid <= 1'b0;
`ifdef XNOR_CROSSCHECK_EN
         mismatch  <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            c_df      <= c_df_comb;
            c_bh      <= c_bh_comb;
            c_st      <= c_st_comb;
            match_cnt <= cnt_comb;
            all_eq    <= (cnt_comb == CNT_W'(WIDTH));
`ifdef XNOR_CROSSCHECK_EN
            if (copies_differ) begin
               mismatch <= 1'b1;
            end
`endif
         end
      end
   end

endmodule : xnor_gate_unit

// File: tb/tb_xnor_gate_unit.sv
// Self-checking bench for xnor_gate_unit: a behavioural reference model,
// a per-cycle compare process and hand-computed directed checks.
module tb_xnor_gate_unit;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c_df;
   logic [WIDTH-1:0] c_bh;
   logic [WIDTH-1:0] c_st;
   logic [CNT_W-1:0] match_cnt;
   logic             all_eq;
   logic             out_valid;
   logic             mismatch;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: what the outputs must show.
   logic [WIDTH-1:0] exp_c;
   int               exp_cnt;
   logic             exp_eq;
   logic             exp_valid;

   xnor_gate_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c_df      (c_df),
      .c_bh      (c_bh),
      .c_st      (c_st),
      .match_cnt (match_cnt),
      .all_eq    (all_eq),
      .out_valid (out_valid),
      .mismatch  (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Model: equality of bits is the complement of their difference; the
   // match count is the number of ones in that result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_c     = '0;
         exp_cnt   = 0;
         exp_eq    = 1'b0;
         exp_valid = 1'b0;
      end else begin
         exp_valid = in_valid;
         if (in_valid) begin
            exp_c   = ~(a ^ b);
            exp_cnt = $countones(~(a ^ b));
            exp_eq  = (a == b);
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      check("cyc_c_df",      32'(c_df),      32'(exp_c));
      check("cyc_c_bh",      32'(c_bh),      32'(exp_c));
      check("cyc_c_st",      32'(c_st),      32'(exp_c));
      check("cyc_match_cnt", 32'(match_cnt), 32'(exp_cnt));
      check("cyc_all_eq",    32'(all_eq),    32'(exp_eq));
      check("cyc_out_valid", 32'(out_valid), 32'(exp_valid));
      check("cyc_mismatch",  32'(mismatch),  32'(0));
   end

   // Apply one vector (called just after a rising edge), then advance to
   // just after the edge that captures it.
   task automatic apply(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vv);
      a        = va;
      b        = vb;
      in_valid = vv;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] c, input int cnt,
                            input logic eq, input logic v);
      check({tag, "_c_df"},      32'(c_df),      32'(c));
      check({tag, "_c_bh"},      32'(c_bh),      32'(c));
      check({tag, "_c_st"},      32'(c_st),      32'(c));
      check({tag, "_match_cnt"}, 32'(match_cnt), 32'(cnt));
      check({tag, "_all_eq"},    32'(all_eq),    32'(eq));
      check({tag, "_out_valid"}, 32'(out_valid), 32'(v));
      check({tag, "_mismatch"},  32'(mismatch),  32'(0));
   endtask

   initial begin
      rst_n    = 1'b0;
      a        = 8'hFF;
      b        = 8'hFF;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 8'h00, 0, 1'b0, 1'b0);
      rst_n = 1'b1;

      apply(8'h00, 8'h00, 1'b1);
      check_all("equal", 8'hFF, 8, 1'b1, 1'b1);

      apply(8'h0F, 8'hFF, 1'b1);
      check_all("partial", 8'h0F, 4, 1'b0, 1'b1);

      apply(8'hA5, 8'h5A, 1'b1);
      check_all("complement", 8'h00, 0, 1'b0, 1'b1);

      apply(8'h3C, 8'h3D, 1'b0);
      check_all("hold", 8'h00, 0, 1'b0, 1'b0);

      apply(8'h81, 8'h80, 1'b1);
      check_all("one_diff", 8'hFE, 7, 1'b0, 1'b1);

      for (int i = 0; i < 1000; i++) begin
         apply(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      // Mid-stream asynchronous reset with a valid result showing.
      apply(8'h12, 8'h12, 1'b1);
      check_all("pre_rst", 8'hFF, 8, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 8'h00, 0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      apply(8'hF0, 8'h00, 1'b1);
      check_all("post_rst", 8'h0F, 4, 1'b0, 1'b1);

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_xnor_gate_unit
